// File: rtl/pulse_stretch_out_pkg.sv
// Shared types for the pulse stretcher: FSM state width and the
// pending-counter update operation chosen each cycle.
package pulse_stretch_out_pkg;

  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  typedef enum logic [1:0] {
    PEND_HOLD = 2'd0,
    PEND_INC  = 2'd1,
    PEND_DEC  = 2'd2
  } pend_op_t;

endpackage

// File: rtl/pulse_stretch_out_cycle_timer.sv
// Loadable down-counter that parks at zero; reusable phase timer for
// pulse, blink and tone style blocks.
module cycle_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // NOTE: registers are written with non-blocking assignments so every
  // flop samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretch_out.sv
// Stretches single-cycle events into visible pin pulses with a minimum
// on time and gap, queuing overlapping requests as a saturating count.
module pulse_stretch_out
  import pulse_stretch_out_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int ON_CYCLES   = 1000,
  parameter int OFF_CYCLES  = 1000,
  parameter int PEND_W      = 4,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EVENT,
  output logic              OUT,
  output logic              BUSY,
  output logic [PEND_W-1:0] PENDING,
  output logic              DROPPED
);

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ON   = 2'd1;
  localparam state_t ST_GAP  = 2'd2;

  localparam logic OUT_ACTIVE   = ACTIVE_HIGH ? 1'b1 : 1'b0;
  localparam logic OUT_INACTIVE = ~OUT_ACTIVE;

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  state_t           state, state_next;
  logic             timer_load;
  logic [CNT_W-1:0] timer_value;
  logic             timer_zero;
  pend_op_t         pend_op;
  logic             drop;

  cycle_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (CLK),
    .rst_n     (RST_N),
    .load      (timer_load),
    .load_value(timer_value),
    .zero      (timer_zero)
  );

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_next  = ST_IDLE;
    timer_load  = 1'b0;
    timer_value = ON_LOAD;
    pend_op     = PEND_HOLD;
    drop        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // A live event starts directly; otherwise drain a count left over
        // from an event that landed on the last gap edge.
        if (EVENT || (PENDING != '0)) begin
          state_next = ST_ON;
          timer_load = 1'b1;
          if (!EVENT) pend_op = PEND_DEC;
        end
      end
      ST_ON: begin
        state_next = ST_ON;
        if (timer_zero) begin
          state_next  = ST_GAP;
          timer_load  = 1'b1;
          timer_value = OFF_LOAD;
        end
        if (EVENT) pend_op = PEND_INC;
      end
      ST_GAP: begin
        state_next = ST_GAP;
        if (timer_zero && (PENDING != '0)) begin
          state_next = ST_ON;
          timer_load = 1'b1;
          pend_op    = EVENT ? PEND_HOLD : PEND_DEC;
        end else begin
          if (timer_zero) state_next = ST_IDLE;
          if (EVENT) pend_op = PEND_INC;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if ((pend_op == PEND_INC) && (PENDING == PEND_MAX)) begin
      pend_op = PEND_HOLD;
      drop    = 1'b1;
    end
  end

  // NOTE: only control state is reset; the timer's reset lives in its own
  // module, and there are no memories here that would need clearing.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      PENDING <= '0;
      DROPPED <= 1'b0;
      OUT     <= OUT_INACTIVE;
    end else begin
      state <= state_next;
      unique case (pend_op)
        PEND_INC: PENDING <= PENDING + 1'b1;
        PEND_DEC: PENDING <= PENDING - 1'b1;
        default:  PENDING <= PENDING;
      endcase
      if (drop) DROPPED <= 1'b1;
      OUT <= (state_next == ST_ON) ? OUT_ACTIVE : OUT_INACTIVE;
    end
  end

  assign BUSY = (state != ST_IDLE) || (PENDING != '0);

endmodule
